// File: rtl/hamming_secded_pipe_decoder.sv
// hamming_secded_pipe_decoder
//   Two-stage pipelined SECDED (extended Hamming) decoder over a valid/ready
//   stream. Single-bit errors are corrected, double-bit errors are flagged,
//   and saturating counters track corrected / uncorrectable output words.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_code[CODE_W]      codeword; bit i = Hamming position i, bit 0 = overall parity
//   out_valid/out_ready  output handshake
//   out_data[DATA_W]     corrected data
//   out_syndrome[PAR_W]  raw syndrome of the word
//   out_status[2]        00 clean, 01 corrected, 10 uncorrectable, 11 parity-bit error
//   cnt_clr              synchronous clear of both counters
//   corr_cnt[CNT_W]      words output with status 01 or 11 (saturating)
//   uncorr_cnt[CNT_W]    words output with status 10 (saturating)

package hamming_secded_pkg;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'b00,
        ST_CORR   = 2'b01,
        ST_UNCORR = 2'b10,
        ST_PARITY = 2'b11
    } status_e;

    // Smallest r with 2^r >= data_w + r + 1. The condition is monotonic in k,
    // so the last failing k fixes the answer.
    function automatic int calc_par_w(input int data_w);
        int r = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << k) < data_w + k + 1) r = k + 1;
        end
        return r;
    endfunction

    // Hamming position of data bit idx: the idx-th non-power-of-two position >= 3.
    function automatic int data_pos(input int idx);
        int seen = 0;
        int pos  = 0;
        int i    = 3;
        while (pos == 0) begin
            if ((i & (i - 1)) != 0) begin
                if (seen == idx) pos = i;
                seen++;
            end
            i++;
        end
        return pos;
    endfunction

endpackage

module hamming_secded_pipe_decoder
    import hamming_secded_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic [1:0]        out_status,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic              s2_ready;
    logic              s1_advance;
    logic              out_fire;

    // Output register can take a word when it is empty or being drained.
    assign s2_ready   = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_fire   = out_valid && out_ready;

    // ---------------- Stage 1: register the codeword ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: payload is qualified by s1_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_code <= in_code;
        end
    end

    // Syndrome = XOR of the position numbers of all set bits (positions >= 1);
    // parity = XOR of every bit including position 0.
    logic [PAR_W-1:0] syn;
    logic             par;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        syn = '0;
        par = s1_code[0];
        for (int i = 1; i < CODE_W; i++) begin
            if (s1_code[i]) begin
                syn = syn ^ PAR_W'(i);
                par = ~par;
            end
        end
    end

    status_e st;
    logic    flip;

    always_comb begin
        st   = ST_CLEAN;
        flip = 1'b0;
        if (syn == '0) begin
            st = par ? ST_PARITY : ST_CLEAN;
        end else if (!par) begin
            st = ST_UNCORR;
        end else if (int'(syn) <= CODE_W - 1) begin
            st   = ST_CORR;
            flip = 1'b1;
        end else begin
            // Syndrome points past the last position: only possible for
            // non-perfect widths, and cannot be a single-bit error.
            st = ST_UNCORR;
        end
    end

    // Only data positions are extracted; a flip aimed at a parity position
    // therefore leaves the data untouched.
    logic [DATA_W-1:0] data;

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        localparam int POS = data_pos(j);
        assign data[j] = s1_code[POS] ^ (flip && (int'(syn) == POS));
    end

    // ---------------- Stage 2: register the result ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_syndrome <= '0;
            out_status   <= ST_CLEAN;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= data;
                out_syndrome <= syn;
                out_status   <= st;
            end
        end
    end

    // ---------------- Saturating error counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_fire) begin
            // Status 01 and 11 both have bit 0 set.
            if (out_status[0] && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (out_status == ST_UNCORR && uncorr_cnt != '1) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_pipe_decoder.sv
// Self-checking bench for hamming_secded_pipe_decoder.
// Three instances: DATA_W=4/CNT_W=16 (main), DATA_W=4/CNT_W=2 (saturation),
// DATA_W=5 (non-perfect width, syndromes can exceed the last position).

module tb_hamming_secded_pipe_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [7:0]  in_code;
    logic [3:0]  out_data;
    logic [2:0]  out_syndrome;
    logic [1:0]  out_status;
    logic [15:0] corr_cnt, uncorr_cnt;

    // saturation instance
    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, cnt_clr_s;
    logic [7:0]  in_code_s;
    logic [3:0]  out_data_s;
    logic [2:0]  out_syndrome_s;
    logic [1:0]  out_status_s;
    logic [1:0]  corr_cnt_s, uncorr_cnt_s;

    // DATA_W=5 instance
    logic        in_valid_f, in_ready_f, out_valid_f, out_ready_f, cnt_clr_f;
    logic [9:0]  in_code_f;
    logic [4:0]  out_data_f;
    logic [3:0]  out_syndrome_f;
    logic [1:0]  out_status_f;
    logic [15:0] corr_cnt_f, uncorr_cnt_f;

    hamming_secded_pipe_decoder #(.DATA_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome), .out_status(out_status),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    hamming_secded_pipe_decoder #(.DATA_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_code(in_code_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_data(out_data_s), .out_syndrome(out_syndrome_s), .out_status(out_status_s),
        .cnt_clr(cnt_clr_s), .corr_cnt(corr_cnt_s), .uncorr_cnt(uncorr_cnt_s)
    );

    hamming_secded_pipe_decoder #(.DATA_W(5), .CNT_W(16)) dut_w5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_f), .in_ready(in_ready_f),
        .in_code(in_code_f), .out_valid(out_valid_f), .out_ready(out_ready_f),
        .out_data(out_data_f), .out_syndrome(out_syndrome_f), .out_status(out_status_f),
        .cnt_clr(cnt_clr_f), .corr_cnt(corr_cnt_f), .uncorr_cnt(uncorr_cnt_f)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        int          syn;
        logic [1:0]  st;
    } exp_t;

    function automatic int par_w_of(input int dw);
        int r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    function automatic logic [31:0] encode(input int dw, input logic [31:0] data);
        int pw = par_w_of(dw);
        int cw = dw + pw + 1;
        int d = 0;
        int s = 0;
        logic [31:0] code = '0;
        for (int i = 1; i < cw; i++)
            if ((i & (i - 1)) != 0) begin code[i] = data[d]; d++; end
        for (int i = 1; i < cw; i++) if (code[i]) s ^= i;
        for (int k = 0; k < pw; k++) code[1 << k] = s[k];
        code[0] = ^code;
        return code;
    endfunction

    function automatic exp_t model(input int dw, input logic [31:0] code);
        exp_t e;
        int pw = par_w_of(dw);
        int cw = dw + pw + 1;
        int d = 0;
        bit p = code[0];
        logic [31:0] fixed;
        e.syn = 0;
        for (int i = 1; i < cw; i++) if (code[i]) begin e.syn ^= i; p = !p; end
        fixed = code;
        if (e.syn == 0)      e.st = p ? 2'b11 : 2'b00;
        else if (!p)         e.st = 2'b10;
        else if (e.syn < cw) begin e.st = 2'b01; fixed[e.syn] = !fixed[e.syn]; end
        else                 e.st = 2'b10;
        e.data = '0;
        for (int i = 1; i < cw; i++)
            if ((i & (i - 1)) != 0) begin e.data[d] = fixed[i]; d++; end
        return e;
    endfunction

    exp_t q_main[$];
    exp_t q_f[$];
    int exp_corr = 0, exp_uncorr = 0, exp_corr_f = 0, exp_uncorr_f = 0;

    // One randomized cycle on the main and DATA_W=5 instances.
    task automatic rand_cycle(input bit drive);
        logic [31:0] c;
        exp_t e;
        int n, pos;
        @(negedge clk);
        out_ready   = drive ? ($urandom_range(0, 3) != 0) : 1'b1;
        out_ready_f = drive ? ($urandom_range(0, 3) != 0) : 1'b1;
        c = encode(4, 32'($urandom_range(0, 15)));
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin pos = $urandom_range(0, 7); c[pos] = !c[pos]; end
        in_valid   = drive && ($urandom_range(0, 3) != 0);
        in_code    = c[7:0];
        in_valid_f = drive && ($urandom_range(0, 3) != 0);
        in_code_f  = 10'($urandom);
        #1;
        if (in_valid && in_ready) q_main.push_back(model(4, 32'(in_code)));
        if (in_valid_f && in_ready_f) q_f.push_back(model(5, 32'(in_code_f)));
        if (out_valid && out_ready) begin
            check("rand_main_expected", 32'(q_main.size() != 0), 1);
            if (q_main.size() != 0) begin
                e = q_main.pop_front();
                check("rand_main_data", 32'(out_data), e.data);
                check("rand_main_syn", 32'(out_syndrome), e.syn);
                check("rand_main_status", 32'(out_status), 32'(e.st));
                if (e.st[0]) exp_corr++; else if (e.st == 2'b10) exp_uncorr++;
            end
        end
        if (out_valid_f && out_ready_f) begin
            check("rand_w5_expected", 32'(q_f.size() != 0), 1);
            if (q_f.size() != 0) begin
                e = q_f.pop_front();
                check("rand_w5_data", 32'(out_data_f), e.data);
                check("rand_w5_syn", 32'(out_syndrome_f), e.syn);
                check("rand_w5_status", 32'(out_status_f), 32'(e.st));
                if (e.st[0]) exp_corr_f++; else if (e.st == 2'b10) exp_uncorr_f++;
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] code;
        logic [3:0] data;
        logic [2:0] syn;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        in_valid = 0; in_code = 0; out_ready = 1; cnt_clr = 0;
        in_valid_s = 0; in_code_s = 0; out_ready_s = 1; cnt_clr_s = 0;
        in_valid_f = 0; in_code_f = 0; out_ready_f = 1; cnt_clr_f = 0;

        vecs[0] = '{8'hAA, 4'hB, 3'd0, 2'b00};  // clean
        vecs[1] = '{8'h8A, 4'hB, 3'd5, 2'b01};  // position 5 flipped
        vecs[2] = '{8'hAB, 4'hB, 3'd0, 2'b11};  // overall parity bit flipped
        vecs[3] = '{8'hAC, 4'hB, 3'd3, 2'b10};  // positions 1 and 2 flipped
        vecs[4] = '{8'h2A, 4'hB, 3'd7, 2'b01};  // highest position flipped
        vecs[5] = '{8'h6A, 4'h7, 3'd1, 2'b10};  // positions 6,7 flipped: data uncorrected
        vecs[6] = '{8'hFF, 4'hF, 3'd0, 2'b00};  // all-ones codeword is valid

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_syndrome", 32'(out_syndrome), 0);
        check("rst_out_status", 32'(out_status), 0);
        check("rst_corr_cnt", 32'(corr_cnt), 0);
        check("rst_uncorr_cnt", 32'(uncorr_cnt), 0);
        @(negedge clk);
        rst_n = 1;

        // Table-driven single words: latency, outputs, counters
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1; in_code = vecs[i].code; out_ready = 1;
            @(negedge clk);
            in_valid = 0;
            check($sformatf("vec%0d_not_yet_valid", i), 32'(out_valid), 0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
            check($sformatf("vec%0d_syn", i), 32'(out_syndrome), 32'(vecs[i].syn));
            check($sformatf("vec%0d_status", i), 32'(out_status), 32'(vecs[i].st));
            if (vecs[i].st[0]) exp_corr++;
            else if (vecs[i].st == 2'b10) exp_uncorr++;
            @(negedge clk);
            check($sformatf("vec%0d_corr_cnt", i), 32'(corr_cnt), exp_corr);
            check($sformatf("vec%0d_uncorr_cnt", i), 32'(uncorr_cnt), exp_uncorr);
            check($sformatf("vec%0d_drained", i), 32'(out_valid), 0);
        end

        // Stream 6 clean words with out_ready low for 5 cycles mid-stream
        begin
            logic [3:0] words[6];
            int si = 0, ri = 0;
            bit saw_bp = 0, was_stalled = 0;
            logic [9:0] held = '0;
            for (int i = 0; i < 6; i++) words[i] = 4'(i * 3 + 1);
            for (int cyc = 0; cyc < 60 && ri < 6; cyc++) begin
                @(negedge clk);
                if (was_stalled)
                    check("stall_hold", 32'({out_valid, out_data, out_syndrome, out_status}), 32'(held));
                out_ready = !(cyc >= 3 && cyc < 8);
                in_valid  = (si < 6);
                in_code   = (si < 6) ? encode(4, 32'(words[si])) : 8'h00;
                #1;
                if (!in_ready) saw_bp = 1;
                if (in_valid && in_ready) si++;
                if (out_valid && out_ready) begin
                    check($sformatf("stall_word%0d", ri), 32'(out_data), 32'(words[ri]));
                    check($sformatf("stall_status%0d", ri), 32'(out_status), 0);
                    ri++;
                end
                was_stalled = out_valid && !out_ready;
                held = {out_valid, out_data, out_syndrome, out_status};
            end
            in_valid = 0;
            check("stall_all_received", ri, 6);
            check("stall_backpressure_seen", 32'(saw_bp), 1);
            out_ready = 1;
            repeat (3) begin
                @(negedge clk);
                check("stall_no_duplicate", 32'(out_valid), 0);
            end
        end

        // Randomized stream against the reference model
        for (int i = 0; i < 400; i++) rand_cycle(1'b1);
        for (int i = 0; i < 10; i++) rand_cycle(1'b0);
        check("rand_main_queue_empty", q_main.size(), 0);
        check("rand_w5_queue_empty", q_f.size(), 0);
        check("rand_main_corr_cnt", 32'(corr_cnt), exp_corr);
        check("rand_main_uncorr_cnt", 32'(uncorr_cnt), exp_uncorr);
        check("rand_w5_corr_cnt", 32'(corr_cnt_f), exp_corr_f);
        check("rand_w5_uncorr_cnt", 32'(uncorr_cnt_f), exp_uncorr_f);

        // Saturation at all-ones with CNT_W=2
        out_ready_s = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_s = 1; in_code_s = 8'h8A;
        end
        @(negedge clk);
        in_valid_s = 0;
        repeat (3) @(negedge clk);
        check("sat_corr_cnt", 32'(corr_cnt_s), 3);
        check("sat_uncorr_cnt", 32'(uncorr_cnt_s), 0);

        // cnt_clr wins over a same-cycle increment
        @(negedge clk);
        in_valid_s = 1; in_code_s = 8'h8A;
        @(negedge clk);
        in_valid_s = 0;
        begin
            int w = 0;
            while (!out_valid_s && w < 5) begin @(negedge clk); w++; end
        end
        check("clr_word_arrived", 32'(out_valid_s), 1);
        cnt_clr_s = 1;
        @(negedge clk);
        cnt_clr_s = 0;
        check("clr_corr_cnt", 32'(corr_cnt_s), 0);

        // Counting resumes after clear
        @(negedge clk);
        in_valid_s = 1; in_code_s = 8'hAB;
        @(negedge clk);
        in_valid_s = 0;
        repeat (3) @(negedge clk);
        check("post_clr_corr_cnt", 32'(corr_cnt_s), 1);

        // Reset pulsed mid-stream
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1; in_code = 8'h8A; out_ready = 1;
            in_valid_s = 1; in_code_s = 8'hAC; out_ready_s = 1;
        end
        @(negedge clk);
        check("midrst_pre_valid", 32'(out_valid), 1);
        #2 rst_n = 0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_valid_sat", 32'(out_valid_s), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_status", 32'(out_status), 0);
        check("midrst_corr_cnt", 32'(corr_cnt), 0);
        check("midrst_uncorr_cnt_sat", 32'(uncorr_cnt_s), 0);
        check("midrst_corr_cnt_sat", 32'(corr_cnt_s), 0);
        in_valid = 0; in_valid_s = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_words_discarded", 32'(out_valid), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
